// File: rtl/counter_sched.sv
// -----------------------------------------------------------------------------
// counter_sched
//
// Round-robin scheduler that lets two requesters (A and B) share one external
// load/increment counter. One request is granted at a time, turned into exactly
// one single-cycle counter command, and the counter's post-update value is
// returned to the owning requester together with a one-cycle acknowledge.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset (shared with
//                       the counter)
//   req_a/op_a/data_a   requester A: level request, op (0 = inc, 1 = load),
//                       load value
//   ack_a, result_a     one-cycle completion pulse and post-op counter value
//   req_b ... result_b  same for requester B
//   cnt_ld, cnt_inc     counter load / increment strobes (one-hot or idle)
//   cnt_data            counter load data
//   cnt_q               counter current value
//   busy                high whenever the scheduler is not IDLE
//   state_o             current FSM state, for observation
//
// Handshake: a requester raises req with op/data stable and keeps them stable
// until it sees its ack. Requests are only sampled in IDLE; the grant edge
// commits the operation, so dropping req or changing op/data afterwards has no
// effect and the ack is still delivered. A req still high in the cycle after
// the ack cycle is taken as a new request.
// -----------------------------------------------------------------------------
module counter_sched #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic             op_a,
  input  logic [WIDTH-1:0] data_a,
  output logic             ack_a,
  output logic [WIDTH-1:0] result_a,
  input  logic             req_b,
  input  logic             op_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             ack_b,
  output logic [WIDTH-1:0] result_b,
  output logic             cnt_ld,
  output logic             cnt_inc,
  output logic [WIDTH-1:0] cnt_data,
  input  logic [WIDTH-1:0] cnt_q,
  output logic             busy,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    ACK     = 2'd3
  } state_e;

  // Owner / pointer encoding: 0 = requester A, 1 = requester B.
  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             owner_q, owner_d;
  logic             cnt_ld_q, cnt_ld_d;
  logic             cnt_inc_q, cnt_inc_d;
  logic [WIDTH-1:0] cnt_data_q, cnt_data_d;
  logic             ack_a_q, ack_a_d;
  logic             ack_b_q, ack_b_d;
  logic [WIDTH-1:0] result_a_q, result_a_d;
  logic [WIDTH-1:0] result_b_q, result_b_d;
  logic             busy_q, busy_d;

  // Grant decode. With a single request the requester wins regardless of the
  // pointer; with both requests the pointer decides.
  logic gnt_a;
  logic gnt_b;
  logic contend;

  assign contend = req_a & req_b;
  assign gnt_a   = req_a & (~req_b | ~ptr_q);
  assign gnt_b   = req_b & (~req_a |  ptr_q);

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    cnt_ld_d   = cnt_ld_q;
    cnt_inc_d  = cnt_inc_q;
    cnt_data_d = cnt_data_q;
    ack_a_d    = 1'b0;
    ack_b_d    = 1'b0;
    result_a_d = result_a_q;
    result_b_d = result_b_q;

    unique case (state_q)
      IDLE: begin
        if (gnt_a) begin
          owner_d    = 1'b0;
          cnt_ld_d   = op_a;
          cnt_inc_d  = ~op_a;
          cnt_data_d = data_a;
          state_d    = ISSUE;
          if (contend) ptr_d = 1'b1;
        end else if (gnt_b) begin
          owner_d    = 1'b1;
          cnt_ld_d   = op_b;
          cnt_inc_d  = ~op_b;
          cnt_data_d = data_b;
          state_d    = ISSUE;
          if (contend) ptr_d = 1'b0;
        end
      end

      ISSUE: begin
        // The counter consumes the strobe on this edge.
        cnt_ld_d  = 1'b0;
        cnt_inc_d = 1'b0;
        state_d   = CAPTURE;
      end

      CAPTURE: begin
        // cnt_q now reflects the completed operation.
        if (owner_q) begin
          result_b_d = cnt_q;
          ack_b_d    = 1'b1;
        end else begin
          result_a_d = cnt_q;
          ack_a_d    = 1'b1;
        end
        state_d = ACK;
      end

      ACK: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Registered busy tracks the state that will be entered on this edge.
    busy_d = (state_d != IDLE);
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      owner_q    <= 1'b0;
      cnt_ld_q   <= 1'b0;
      cnt_inc_q  <= 1'b0;
      cnt_data_q <= '0;
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
      result_a_q <= '0;
      result_b_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      cnt_ld_q   <= cnt_ld_d;
      cnt_inc_q  <= cnt_inc_d;
      cnt_data_q <= cnt_data_d;
      ack_a_q    <= ack_a_d;
      ack_b_q    <= ack_b_d;
      result_a_q <= result_a_d;
      result_b_q <= result_b_d;
      busy_q     <= busy_d;
    end
  end

  assign ack_a    = ack_a_q;
  assign ack_b    = ack_b_q;
  assign result_a = result_a_q;
  assign result_b = result_b_q;
  assign cnt_ld   = cnt_ld_q;
  assign cnt_inc  = cnt_inc_q;
  assign cnt_data = cnt_data_q;
  assign busy     = busy_q;
  assign state_o  = state_q;

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_strobe_onehot: assert property (@(posedge clk) disable iff (rst)
    !(cnt_ld_q && cnt_inc_q));

  a_strobe_in_issue: assert property (@(posedge clk) disable iff (rst)
    (cnt_ld_q || cnt_inc_q) |-> (state_q == ISSUE));

  a_ack_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(ack_a_q && ack_b_q));

  a_ack_in_ack_state: assert property (@(posedge clk) disable iff (rst)
    (ack_a_q || ack_b_q) |-> (state_q == ACK));

endmodule
